// File: rtl/jtag_tap_pkg.sv
// jtag_tap_pkg
// Shared types and constants for the clock-sampled JTAG TAP responder:
// the 16-state TAP state type, the data-register selector, the instruction
// opcodes, the IR capture pattern and the TAP next-state function.
package jtag_tap_pkg;

  typedef enum logic [3:0] {
    TLR,
    RTI,
    SEL_DR,
    CAP_DR,
    SH_DR,
    EX1_DR,
    PA_DR,
    EX2_DR,
    UPD_DR,
    SEL_IR,
    CAP_IR,
    SH_IR,
    EX1_IR,
    PA_IR,
    EX2_IR,
    UPD_IR
  } tap_state_e;

  typedef enum logic [1:0] {
    SEL_BYPASS,
    SEL_IDCODE,
    SEL_USER
  } dr_sel_e;

  localparam logic [4:0] IR_IDCODE  = 5'b00001;
  localparam logic [4:0] IR_USER    = 5'b00100;
  localparam logic [4:0] IR_BYPASS  = 5'b11111;
  localparam logic [4:0] IR_CAPTURE = 5'b00101;

  // Standard TAP transition taken on a TCK rising edge.
  function automatic tap_state_e tap_next(input tap_state_e state, input logic tms);
    tap_state_e nxt;
    nxt = TLR;
    case (state)
      TLR:     nxt = tms ? TLR    : RTI;
      RTI:     nxt = tms ? SEL_DR : RTI;
      SEL_DR:  nxt = tms ? SEL_IR : CAP_DR;
      CAP_DR:  nxt = tms ? EX1_DR : SH_DR;
      SH_DR:   nxt = tms ? EX1_DR : SH_DR;
      EX1_DR:  nxt = tms ? UPD_DR : PA_DR;
      PA_DR:   nxt = tms ? EX2_DR : PA_DR;
      EX2_DR:  nxt = tms ? UPD_DR : SH_DR;
      UPD_DR:  nxt = tms ? SEL_DR : RTI;
      SEL_IR:  nxt = tms ? TLR    : CAP_IR;
      CAP_IR:  nxt = tms ? EX1_IR : SH_IR;
      SH_IR:   nxt = tms ? EX1_IR : SH_IR;
      EX1_IR:  nxt = tms ? UPD_IR : PA_IR;
      PA_IR:   nxt = tms ? EX2_IR : PA_IR;
      EX2_IR:  nxt = tms ? UPD_IR : SH_IR;
      UPD_IR:  nxt = tms ? SEL_DR : RTI;
      default: nxt = TLR;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/jtag_tap_sampled_in_sync.sv
// jtag_in_sync
// Brings the four asynchronous JTAG pins into the system clock domain and
// turns TCK transitions into single-clk strobes.
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   tck_i/tms_i/tdi_i/trstn_i  raw JTAG pins
//   tms_s/tdi_s/trstn_s synchronized pin values
//   tck_rise/tck_fall   one-clk strobes on synchronized TCK edges
module jtag_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic tck_i,
  input  logic tms_i,
  input  logic tdi_i,
  input  logic trstn_i,
  output logic tms_s,
  output logic tdi_s,
  output logic trstn_s,
  output logic tck_rise,
  output logic tck_fall
);

  // Bit order {trstn, tdi, tms, tck}; trstn comes out of reset deasserted.
  localparam logic [3:0] SYNC_RESET = 4'b1000;

  logic [3:0] sync_q [SYNC_STAGES];
  logic       tck_hist_q;
  logic       tck_s;

  // Pin synchronizer chain plus one extra TCK history flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RESET;
      tck_hist_q <= 1'b0;
    end else begin
      sync_q[0] <= {trstn_i, tdi_i, tms_i, tck_i};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      tck_hist_q <= sync_q[SYNC_STAGES-1][0];
    end
  end

  assign {trstn_s, tdi_s, tms_s, tck_s} = sync_q[SYNC_STAGES-1];
  assign tck_rise = tck_s & ~tck_hist_q;
  assign tck_fall = ~tck_s & tck_hist_q;

endmodule

// File: rtl/jtag_tap_sampled.sv
// jtag_tap_sampled
// Device-side JTAG TAP that runs entirely on the system clock by
// oversampling the JTAG pins. Implements IDCODE, USER and BYPASS data
// registers; the USER register is captured from and updated to on-chip logic.
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   tck_i, tms_i, tdi_i, trstn_i   asynchronous JTAG pins
//   tdo_o, tdo_oe_o JTAG data out and its drive enable (shift states only)
//   user_rdata_i    value captured into USER DR at Capture-DR
//   user_capture_o  one-clk pulse when USER DR captures
//   user_wdata_o    USER DR contents at the last USER Update-DR
//   user_wvalid_o   one-clk pulse on USER Update-DR
module jtag_tap_sampled
  import jtag_tap_pkg::*;
#(
  parameter int          IR_WIDTH    = 5,
  parameter int          DR_WIDTH    = 32,
  parameter logic [31:0] IDCODE_VAL  = 32'h1000_5AD1,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tck_i,
  input  logic                tms_i,
  input  logic                tdi_i,
  input  logic                trstn_i,
  output logic                tdo_o,
  output logic                tdo_oe_o,
  input  logic [DR_WIDTH-1:0] user_rdata_i,
  output logic                user_capture_o,
  output logic [DR_WIDTH-1:0] user_wdata_o,
  output logic                user_wvalid_o
);

  logic tms_s, tdi_s, trstn_s, tck_rise, tck_fall;

  tap_state_e state_q, state_d;
  dr_sel_e    dr_sel;

  logic [IR_WIDTH-1:0] ir_q, ir_shift_q;
  logic [31:0]         id_shift_q;
  logic [DR_WIDTH-1:0] user_shift_q;
  logic                bypass_q;
  logic                dr_lsb;

  jtag_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_in_sync (
    .clk      (clk),
    .rst      (rst),
    .tck_i    (tck_i),
    .tms_i    (tms_i),
    .tdi_i    (tdi_i),
    .trstn_i  (trstn_i),
    .tms_s    (tms_s),
    .tdi_s    (tdi_s),
    .trstn_s  (trstn_s),
    .tck_rise (tck_rise),
    .tck_fall (tck_fall)
  );

  // TAP state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= TLR;
    else     state_q <= state_d;
  end

  // Next state: TRSTn overrides any coincident TCK rise.
  always_comb begin
    state_d = state_q;
    if (!trstn_s)      state_d = TLR;
    else if (tck_rise) state_d = tap_next(state_q, tms_s);
  end

  // Unrecognised opcodes fall through to BYPASS.
  always_comb begin
    dr_sel = SEL_BYPASS;
    if (ir_q == IR_WIDTH'(IR_IDCODE))    dr_sel = SEL_IDCODE;
    else if (ir_q == IR_WIDTH'(IR_USER)) dr_sel = SEL_USER;
  end

  always_comb begin
    dr_lsb = bypass_q;
    case (dr_sel)
      SEL_IDCODE: dr_lsb = id_shift_q[0];
      SEL_USER:   dr_lsb = user_shift_q[0];
      default:    dr_lsb = bypass_q;
    endcase
  end

  // IR/DR datapath: capture/shift/update on TCK rise, TDO launch on TCK fall.
  // user_wdata_o survives TRSTn; only rst clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_q           <= IR_WIDTH'(IR_IDCODE);
      ir_shift_q     <= '0;
      id_shift_q     <= '0;
      user_shift_q   <= '0;
      bypass_q       <= 1'b0;
      user_wdata_o   <= '0;
      user_capture_o <= 1'b0;
      user_wvalid_o  <= 1'b0;
      tdo_o          <= 1'b0;
      tdo_oe_o       <= 1'b0;
    end else begin
      user_capture_o <= 1'b0;
      user_wvalid_o  <= 1'b0;
      if (!trstn_s) begin
        ir_q     <= IR_WIDTH'(IR_IDCODE);
        tdo_oe_o <= 1'b0;
      end else begin
        if (state_q == TLR) ir_q <= IR_WIDTH'(IR_IDCODE);
        if (tck_rise) begin
          case (state_q)
            CAP_IR: ir_shift_q <= IR_WIDTH'(IR_CAPTURE);
            SH_IR:  ir_shift_q <= {tdi_s, ir_shift_q[IR_WIDTH-1:1]};
            UPD_IR: ir_q <= ir_shift_q;
            CAP_DR: begin
              case (dr_sel)
                SEL_IDCODE: id_shift_q <= IDCODE_VAL;
                SEL_USER: begin
                  user_shift_q   <= user_rdata_i;
                  user_capture_o <= 1'b1;
                end
                default: bypass_q <= 1'b0;
              endcase
            end
            SH_DR: begin
              case (dr_sel)
                SEL_IDCODE: id_shift_q   <= {tdi_s, id_shift_q[31:1]};
                SEL_USER:   user_shift_q <= {tdi_s, user_shift_q[DR_WIDTH-1:1]};
                default:    bypass_q     <= tdi_s;
              endcase
            end
            UPD_DR: begin
              if (dr_sel == SEL_USER) begin
                user_wdata_o  <= user_shift_q;
                user_wvalid_o <= 1'b1;
              end
            end
            default: ;
          endcase
        end
        if (tck_fall) begin
          tdo_oe_o <= (state_q == SH_IR) || (state_q == SH_DR);
          if (state_q == SH_IR)      tdo_o <= ir_shift_q[0];
          else if (state_q == SH_DR) tdo_o <= dr_lsb;
        end
      end
    end
  end

endmodule

// File: tb/tb_jtag_tap_sampled.sv
// tb_jtag_tap_sampled
// Self-checking bench for jtag_tap_sampled. Drives TCK/TMS/TDI like a JTAG
// host, runs a table of directed scans, randomized scans against a
// scan-stream reference model, and hand-written TRSTn / rst abort sequences.
module tb_jtag_tap_sampled;

  localparam logic [31:0] IDCODE_VAL = 32'h1000_5AD1;
  localparam int          TCK_HALF   = 6;

  logic        clk = 1'b0;
  logic        rst, tck_i, tms_i, tdi_i, trstn_i;
  logic        tdo_o, tdo_oe_o;
  logic [31:0] user_rdata_i, user_wdata_o;
  logic        user_capture_o, user_wvalid_o;

  int n_checks = 0;
  int n_fails  = 0;
  int n_capture = 0;
  int n_wvalid  = 0;

  always #5 clk = ~clk;

  jtag_tap_sampled #(
    .IR_WIDTH(5), .DR_WIDTH(32), .IDCODE_VAL(IDCODE_VAL), .SYNC_STAGES(2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .tck_i          (tck_i),
    .tms_i          (tms_i),
    .tdi_i          (tdi_i),
    .trstn_i        (trstn_i),
    .tdo_o          (tdo_o),
    .tdo_oe_o       (tdo_oe_o),
    .user_rdata_i   (user_rdata_i),
    .user_capture_o (user_capture_o),
    .user_wdata_o   (user_wdata_o),
    .user_wvalid_o  (user_wvalid_o)
  );

  // Pulse counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (user_capture_o) n_capture++;
    if (user_wvalid_o)  n_wvalid++;
  end

  // Global time bound so the run always terminates.
  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // One full TCK period; returns TDO/OE as seen by the host just before the rise.
  task automatic applyStimulus(input logic tms, input logic tdi, output logic tdo, output logic oe);
    tms_i = tms;
    tdi_i = tdi;
    repeat (TCK_HALF) @(negedge clk);
    tdo = tdo_o;
    oe  = tdo_oe_o;
    tck_i = 1'b1;
    repeat (TCK_HALF) @(negedge clk);
    tck_i = 1'b0;
    repeat (TCK_HALF) @(negedge clk);
  endtask

  task automatic goto_tlr();
    logic t, o;
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, t, o);
  endtask

  // From RTI: load an instruction, end back in RTI.
  task automatic scan_ir(input logic [4:0] code, output logic [4:0] tdo_bits, output int oe_cnt);
    logic t, o;
    oe_cnt = 0;
    tdo_bits = '0;
    applyStimulus(1'b1, 1'b0, t, o); oe_cnt += int'(o);
    applyStimulus(1'b1, 1'b0, t, o); oe_cnt += int'(o);
    applyStimulus(1'b0, 1'b0, t, o); oe_cnt += int'(o);
    applyStimulus(1'b0, 1'b0, t, o); oe_cnt += int'(o);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(i == 4, code[i], t, o);
      tdo_bits[i] = t;
      oe_cnt += int'(o);
    end
    applyStimulus(1'b1, 1'b0, t, o); oe_cnt += int'(o);
    applyStimulus(1'b0, 1'b0, t, o); oe_cnt += int'(o);
  endtask

  // From RTI: n-bit DR scan, optionally parked in Pause-DR after pause_at bits.
  task automatic scan_dr(input int n, input logic [63:0] tdi, input int pause_at, input int pause_len,
                         output logic [63:0] tdo_bits, output int oe_cnt);
    logic t, o;
    oe_cnt = 0;
    tdo_bits = '0;
    applyStimulus(1'b1, 1'b0, t, o); oe_cnt += int'(o);
    applyStimulus(1'b0, 1'b0, t, o); oe_cnt += int'(o);
    applyStimulus(1'b0, 1'b0, t, o); oe_cnt += int'(o);
    for (int i = 0; i < n; i++) begin
      logic do_pause;
      do_pause = (pause_at > 0) && (i == pause_at - 1) && (i != n - 1);
      applyStimulus((i == n - 1) || do_pause, tdi[i], t, o);
      tdo_bits[i] = t;
      oe_cnt += int'(o);
      if (do_pause) begin
        applyStimulus(1'b0, 1'b0, t, o); oe_cnt += int'(o);
        for (int p = 0; p < pause_len; p++) begin
          applyStimulus(1'b0, 1'b0, t, o); oe_cnt += int'(o);
        end
        applyStimulus(1'b1, 1'b0, t, o); oe_cnt += int'(o);
        applyStimulus(1'b0, 1'b0, t, o); oe_cnt += int'(o);
      end
    end
    applyStimulus(1'b1, 1'b0, t, o); oe_cnt += int'(o);
    applyStimulus(1'b0, 1'b0, t, o); oe_cnt += int'(o);
  endtask

  // Reference model: a DR scan is one serial stream made of the captured
  // register (LSB first) followed by the TDI bits. TDO bit i is stream[i];
  // after n shifts the register holds stream[n .. n+len-1].
  function automatic int model_len(input logic [4:0] ir);
    return (ir == 5'b00001 || ir == 5'b00100) ? 32 : 1;
  endfunction

  function automatic logic [63:0] model_cap(input logic [4:0] ir, input logic [31:0] rdata);
    if (ir == 5'b00001) return {32'd0, IDCODE_VAL};
    if (ir == 5'b00100) return {32'd0, rdata};
    return 64'd0;
  endfunction

  function automatic logic model_stream(input int len, input logic [63:0] cap, input logic [63:0] tdi, input int k);
    return (k < len) ? cap[k] : tdi[k - len];
  endfunction

  typedef struct {
    logic [4:0]  ir;
    logic [31:0] rdata;
    logic [63:0] tdi;
    int          n;
    int          pause_at;
    logic [63:0] exp_tdo;
    int          exp_wv;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [4:0]  ir_tdo;
    logic [63:0] dr_tdo, exp_tdo, tdi;
    logic [31:0] model_wdata, exp_wdata;
    logic [4:0]  ir;
    logic        t, o;
    int          oe_cnt, wv0, cap0, n, pause_at, len;

    vecs[0] = '{5'b00001, 32'h0,         64'h0,         32, 0,  64'h1000_5AD1, 0, 32'h0};
    vecs[1] = '{5'b00100, 32'hCAFE_F00D, 64'h1234_5678, 32, 0,  64'hCAFE_F00D, 1, 32'h1234_5678};
    vecs[2] = '{5'b11111, 32'h0,         64'hA5,        8,  0,  64'h4A,        0, 32'h1234_5678};
    vecs[3] = '{5'b01010, 32'h0,         64'hA5,        8,  0,  64'h4A,        0, 32'h1234_5678};
    vecs[4] = '{5'b00100, 32'h0BAD_BEEF, 64'h8765_4321, 32, 16, 64'h0BAD_BEEF, 1, 32'h8765_4321};

    rst = 1'b1; tck_i = 1'b0; tms_i = 1'b1; tdi_i = 1'b0; trstn_i = 1'b1; user_rdata_i = '0;
    repeat (4) @(negedge clk);
    checkOutput("reset tdo", {63'd0, tdo_o}, 64'd0);
    checkOutput("reset tdo_oe", {63'd0, tdo_oe_o}, 64'd0);
    checkOutput("reset wdata", {32'd0, user_wdata_o}, 64'd0);
    checkOutput("reset pulses", {62'd0, user_capture_o, user_wvalid_o}, 64'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // IDCODE straight out of reset, no IR scan.
    goto_tlr();
    applyStimulus(1'b0, 1'b0, t, o);
    scan_dr(32, 64'd0, 0, 0, dr_tdo, oe_cnt);
    checkOutput("idcode tdo", dr_tdo, {32'd0, IDCODE_VAL});
    checkOutput("idcode oe count", 64'(oe_cnt), 64'd32);
    checkOutput("idcode no capture", 64'(n_capture), 64'd0);

    // Directed table.
    for (int v = 0; v < 5; v++) begin
      user_rdata_i = vecs[v].rdata;
      wv0 = n_wvalid;
      scan_ir(vecs[v].ir, ir_tdo, oe_cnt);
      checkOutput($sformatf("vec%0d ir capture", v), {59'd0, ir_tdo}, 64'h05);
      checkOutput($sformatf("vec%0d ir oe count", v), 64'(oe_cnt), 64'd5);
      scan_dr(vecs[v].n, vecs[v].tdi, vecs[v].pause_at, 10, dr_tdo, oe_cnt);
      checkOutput($sformatf("vec%0d dr tdo", v), dr_tdo, vecs[v].exp_tdo);
      checkOutput($sformatf("vec%0d dr oe count", v), 64'(oe_cnt), 64'(vecs[v].n));
      checkOutput($sformatf("vec%0d wvalid", v), 64'(n_wvalid - wv0), 64'(vecs[v].exp_wv));
      checkOutput($sformatf("vec%0d wdata", v), {32'd0, user_wdata_o}, {32'd0, vecs[v].exp_wdata});
    end
    model_wdata = 32'h8765_4321;

    // Randomized scans against the stream model.
    for (int r = 0; r < 8; r++) begin
      case ($urandom_range(0, 3))
        0:       ir = 5'b00001;
        1:       ir = 5'b00100;
        2:       ir = 5'b11111;
        default: ir = 5'($urandom);
      endcase
      user_rdata_i = $urandom;
      tdi = {$urandom, $urandom};
      n = $urandom_range(24, 40);
      pause_at = ($urandom_range(0, 1) == 1) ? $urandom_range(1, n - 1) : 0;
      len = model_len(ir);
      exp_tdo = '0;
      for (int i = 0; i < n; i++) exp_tdo[i] = model_stream(len, model_cap(ir, user_rdata_i), tdi, i);
      exp_wdata = model_wdata;
      if (ir == 5'b00100)
        for (int j = 0; j < 32; j++) exp_wdata[j] = model_stream(32, model_cap(ir, user_rdata_i), tdi, j + n);
      wv0 = n_wvalid;
      cap0 = n_capture;
      scan_ir(ir, ir_tdo, oe_cnt);
      checkOutput($sformatf("rnd%0d ir capture", r), {59'd0, ir_tdo}, 64'h05);
      scan_dr(n, tdi, pause_at, 3, dr_tdo, oe_cnt);
      checkOutput($sformatf("rnd%0d dr tdo", r), dr_tdo, exp_tdo);
      checkOutput($sformatf("rnd%0d dr oe count", r), 64'(oe_cnt), 64'(n));
      checkOutput($sformatf("rnd%0d wvalid", r), 64'(n_wvalid - wv0), (ir == 5'b00100) ? 64'd1 : 64'd0);
      checkOutput($sformatf("rnd%0d capture", r), 64'(n_capture - cap0), (ir == 5'b00100) ? 64'd1 : 64'd0);
      checkOutput($sformatf("rnd%0d wdata", r), {32'd0, user_wdata_o}, {32'd0, exp_wdata});
      model_wdata = exp_wdata;
    end

    // TRSTn in the middle of a USER DR shift.
    scan_ir(5'b00100, ir_tdo, oe_cnt);
    wv0 = n_wvalid;
    applyStimulus(1'b1, 1'b0, t, o);
    applyStimulus(1'b0, 1'b0, t, o);
    applyStimulus(1'b0, 1'b0, t, o);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'($urandom), t, o);
    trstn_i = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("trst tdo_oe", {63'd0, tdo_oe_o}, 64'd0);
    trstn_i = 1'b1;
    repeat (6) @(negedge clk);
    applyStimulus(1'b0, 1'b0, t, o);
    scan_dr(32, 64'd0, 0, 0, dr_tdo, oe_cnt);
    checkOutput("trst idcode tdo", dr_tdo, {32'd0, IDCODE_VAL});
    checkOutput("trst no wvalid", 64'(n_wvalid - wv0), 64'd0);
    checkOutput("trst wdata kept", {32'd0, user_wdata_o}, {32'd0, model_wdata});

    // rst in the middle of an IR shift.
    applyStimulus(1'b1, 1'b0, t, o);
    applyStimulus(1'b1, 1'b0, t, o);
    applyStimulus(1'b0, 1'b0, t, o);
    applyStimulus(1'b0, 1'b0, t, o);
    applyStimulus(1'b0, 1'b1, t, o);
    applyStimulus(1'b0, 1'b1, t, o);
    checkOutput("pre-rst tdo", {62'd0, tdo_o, tdo_oe_o}, 64'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst tdo/oe", {62'd0, tdo_o, tdo_oe_o}, 64'd0);
    checkOutput("rst wdata", {32'd0, user_wdata_o}, 64'd0);
    checkOutput("rst pulses", {62'd0, user_capture_o, user_wvalid_o}, 64'd0);
    repeat (6) @(negedge clk);
    applyStimulus(1'b0, 1'b0, t, o);
    scan_dr(32, 64'd0, 0, 0, dr_tdo, oe_cnt);
    checkOutput("rst idcode tdo", dr_tdo, {32'd0, IDCODE_VAL});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
